// File: rtl/rv32v_uop_sequencer_if.sv
// Handshake bundle between decode, the uop sequencer and the vector lanes.
// The master side is decode plus the lanes; the slave side is the sequencer.
interface rv32v_uop_sequencer_if #(
  parameter int VLEN  = 128,
  parameter int LANES = 4
);
  localparam int ElemOffW = $clog2(VLEN/8);

  logic                flush;
  logic                insn_valid;
  logic                insn_ready;
  logic [31:0]         insn_vl;
  logic [1:0]          insn_vsew;
  logic [2:0]          insn_vlmul;
  logic                insn_vill;
  logic [31:0]         insn_vstart;
  logic                uop_valid;
  logic                uop_ready;
  logic [2:0]          uop_vreg_off;
  logic [ElemOffW-1:0] uop_elem_off;
  logic [LANES-1:0]    uop_mask;
  logic                uop_last;
  logic                seq_done;

  modport master (
    output flush, insn_valid, insn_vl, insn_vsew, insn_vlmul, insn_vill, insn_vstart, uop_ready,
    input  insn_ready, uop_valid, uop_vreg_off, uop_elem_off, uop_mask, uop_last, seq_done
  );

  modport slave (
    input  flush, insn_valid, insn_vl, insn_vsew, insn_vlmul, insn_vill, insn_vstart, uop_ready,
    output insn_ready, uop_valid, uop_vreg_off, uop_elem_off, uop_mask, uop_last, seq_done
  );
endinterface

// File: rtl/rv32v_uop_sequencer.sv
// Splits one decoded vector instruction into LANES-wide micro-ops for the vector lanes.
// Optional feature macro: RV32V_VSTART_EN (honour insn_vstart as the first element index).
module rv32v_uop_sequencer #(
  parameter int VLEN  = 128,
  parameter int LANES = 4
) (
  input logic                  CLK,
  input logic                  nRST,
  rv32v_uop_sequencer_if.slave bus
);

  localparam int ElemOffW    = $clog2(VLEN/8);
  localparam int EprLog2Base = $clog2(VLEN) - 3;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e      state_q;
  logic [31:0] elemIdx_q;
  logic [31:0] vl_q;
  logic [1:0]  vsew_q;

  logic             insnLegal;
  logic [31:0]      insnVlmax;
  logic [31:0]      effVl_d;
  logic [31:0]      start_d;
  logic [31:0]      elemStart_d;
  logic [LANES-1:0] headMask_d;
  logic [LANES-1:0] headMask;
  logic [LANES-1:0] laneMask;
  logic [31:0]      eprMask;
  logic [2:0]       vregOff;
  logic [ElemOffW-1:0] elemOff;
  logic             uopLast;
  logic             running;

  // Clamp the speculative vl to VLMAX; any illegal vtype collapses to zero elements.
  always_comb begin
    insnLegal = ~bus.insn_vill && (bus.insn_vsew != 2'd3) && ~bus.insn_vlmul[2];
    insnVlmax = (32'(VLEN) >> (32'd3 + 32'(bus.insn_vsew))) << bus.insn_vlmul[1:0];
    effVl_d   = '0;
    if (insnLegal) begin
      effVl_d = (bus.insn_vl > insnVlmax) ? insnVlmax : bus.insn_vl;
    end
  end

`ifdef RV32V_VSTART_EN
  logic [LANES-1:0] headMask_q;

  // A vstart past the end means nothing to do, so it is pinned to eff_vl.
  always_comb begin
    start_d     = (bus.insn_vstart < effVl_d) ? bus.insn_vstart : effVl_d;
    elemStart_d = start_d & ~32'(LANES - 1);
    headMask_d  = '0;
    for (int i = 0; i < LANES; i++) begin
      headMask_d[i] = (32'(i) >= (start_d & 32'(LANES - 1)));
    end
  end

  assign headMask = headMask_q;
`else
  logic unusedVstart;

  assign unusedVstart = ^bus.insn_vstart;
  assign start_d      = '0;
  assign elemStart_d  = '0;
  assign headMask_d   = '1;
  assign headMask     = '1;
`endif

  // LANES divides the elements-per-register count, so a plain shift/mask splits the index.
  always_comb begin
    int eprLog2;
    eprLog2  = EprLog2Base - int'(vsew_q);
    eprMask  = (32'd1 << eprLog2) - 32'd1;
    vregOff  = 3'(elemIdx_q >> eprLog2);
    elemOff  = ElemOffW'(elemIdx_q & eprMask);
    uopLast  = (elemIdx_q + 32'(LANES)) >= vl_q;
    laneMask = '0;
    for (int i = 0; i < LANES; i++) begin
      laneMask[i] = (elemIdx_q + 32'(i)) < vl_q;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      elemIdx_q <= '0;
      vl_q      <= '0;
      vsew_q    <= '0;
`ifdef RV32V_VSTART_EN
      headMask_q <= '1;
`endif
    end else if (bus.flush) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.insn_valid) begin
            vl_q      <= effVl_d;
            vsew_q    <= bus.insn_vsew;
            elemIdx_q <= elemStart_d;
            state_q   <= (effVl_d == start_d) ? DONE : RUN;
`ifdef RV32V_VSTART_EN
            headMask_q <= headMask_d;
`endif
          end
        end
        RUN: begin
          if (bus.uop_ready) begin
            if (uopLast) begin
              state_q <= DONE;
            end else begin
              elemIdx_q <= elemIdx_q + 32'(LANES);
            end
`ifdef RV32V_VSTART_EN
            headMask_q <= '1;
`endif
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Flush wins in its own cycle: no uop and no completion pulse escape.
  assign running          = (state_q == RUN);
  assign bus.insn_ready   = (state_q == IDLE);
  assign bus.uop_valid    = running & ~bus.flush;
  assign bus.seq_done     = (state_q == DONE) & ~bus.flush;
  assign bus.uop_vreg_off = running ? vregOff : '0;
  assign bus.uop_elem_off = running ? elemOff : '0;
  assign bus.uop_mask     = running ? (laneMask & headMask) : '0;
  assign bus.uop_last     = running & uopLast;

endmodule
